// File: rtl/bcd_to_bin_seq_if.sv
// rtl/bcd_to_bin_seq_if.sv - start/busy/done handshake bundle for the BCD-to-binary converter
// Purpose: groups the request side (start, bcd) and result side (bin, busy, done, err).
// Signals:
//   start  request a conversion (master -> slave)
//   bcd    packed BCD digits, digit 0 in bits [3:0] (master -> slave)
//   bin    converted binary value (slave -> master)
//   busy   conversion in progress (slave -> master)
//   done   one-cycle result-valid pulse (slave -> master)
//   err    last accepted input held a digit > 9 (slave -> master)
interface bcd_to_bin_seq_if #(
  parameter int N_DIG = 2,
  parameter int BIN_W = 7
) ();
  logic               start;
  logic [4*N_DIG-1:0] bcd;
  logic [BIN_W-1:0]   bin;
  logic               busy;
  logic               done;
  logic               err;

  modport master (output start, output bcd, input bin, input busy, input done, input err);
  modport slave  (input start, input bcd, output bin, output busy, output done, output err);
endinterface

// File: rtl/bcd_to_bin_seq.sv
// rtl/bcd_to_bin_seq.sv - sequential BCD-to-binary converter (reverse double-dabble)
// Purpose: converts N_DIG packed BCD digits to binary over 4*N_DIG shift cycles.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    slave side of bcd_to_bin_seq_if (start, bcd in; bin, busy, done, err out)
module bcd_to_bin_seq #(
  parameter int N_DIG = 2,
  parameter int BIN_W = 7
) (
  input logic             clk,
  input logic             rst_n,
  bcd_to_bin_seq_if.slave bus
);
  localparam int HALF  = 4 * N_DIG;
  localparam int SR_W  = 2 * HALF;
  localparam int CNT_W = $clog2(HALF + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [SR_W-1:0]  r_sr, w_sr_nxt, w_sr_step;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [BIN_W-1:0] r_bin, w_bin_nxt;
  logic             r_err, w_err_nxt;
  logic             w_bad_digit;
  logic             w_accept;
  logic             w_last_shift;

  // Any digit above 9, including the most significant one, rejects the input.
  always_comb begin
    w_bad_digit = 1'b0;
    for (int k = 0; k < N_DIG; k++) begin
      if (bus.bcd[4*k +: 4] > 4'd9) w_bad_digit = 1'b1;
    end
  end

  // One reverse double-dabble step: shift first, then correct every upper-half
  // nibble from its post-shift value, all nibbles in parallel.
  always_comb begin
    w_sr_step = r_sr >> 1;
    for (int k = 0; k < N_DIG; k++) begin
      if (w_sr_step[HALF+4*k +: 4] >= 4'd8)
        w_sr_step[HALF+4*k +: 4] = w_sr_step[HALF+4*k +: 4] - 4'd3;
    end
  end

  assign w_last_shift = (r_cnt == CNT_W'(HALF - 1));
  // DONE accepts a new start like IDLE, so conversions can run back to back.
  assign w_accept     = bus.start && (r_state != S_SHIFT);

  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_cnt_nxt   = r_cnt;
    w_bin_nxt   = r_bin;
    w_err_nxt   = r_err;

    case (r_state)
      S_SHIFT: begin
        w_sr_nxt  = w_sr_step;
        w_cnt_nxt = r_cnt + 1'b1;
        if (w_last_shift) begin
          w_state_nxt = S_DONE;
          // Register the result on the way into DONE so bin is valid with done.
          w_bin_nxt   = BIN_W'(w_sr_step[HALF-1:0]);
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_accept) begin
      if (w_bad_digit) begin
        w_bin_nxt   = '0;
        w_err_nxt   = 1'b1;
        w_state_nxt = S_DONE;
      end else begin
        w_sr_nxt    = {bus.bcd, {HALF{1'b0}}};
        w_cnt_nxt   = '0;
        w_err_nxt   = 1'b0;
        w_state_nxt = S_SHIFT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_bin   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sr    <= w_sr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bin   <= w_bin_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign bus.bin  = r_bin;
  assign bus.busy = (r_state == S_SHIFT);
  assign bus.done = (r_state == S_DONE);
  assign bus.err  = r_err;
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb/tb_bcd_to_bin_seq.sv - self-checking bench for bcd_to_bin_seq
module tb_bcd_to_bin_seq;
  localparam int N_DIG = 2;
  localparam int BIN_W = 7;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  bcd_to_bin_seq_if #(.N_DIG(N_DIG), .BIN_W(BIN_W)) bus ();

  bcd_to_bin_seq #(.N_DIG(N_DIG), .BIN_W(BIN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit ref_valid(input logic [7:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9);
  endfunction

  function automatic int ref_value(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  // Starts a conversion at the current falling edge and waits for done.
  // Leaves the bench on the falling edge where done is high, start low.
  task automatic conv(input logic [7:0] v, input string tag);
    int cyc;
    int nbusy;
    bit valid;
    valid     = ref_valid(v);
    bus.start = 1'b1;
    bus.bcd   = v;
    @(negedge clk);
    bus.start = 1'b0;
    bus.bcd   = 8'($urandom);
    cyc       = 1;
    nbusy     = 0;
    while (!bus.done && cyc < 20) begin
      if (bus.busy) nbusy++;
      @(negedge clk);
      bus.bcd = 8'($urandom);
      cyc++;
    end
    chk({tag, "_latency"}, cyc, valid ? 9 : 1);
    chk({tag, "_busy_cycles"}, nbusy, valid ? 8 : 0);
    chk({tag, "_busy_at_done"}, bus.busy, 0);
    chk({tag, "_bin"}, bus.bin, valid ? ref_value(v) : 0);
    chk({tag, "_err"}, bus.err, valid ? 0 : 1);
  endtask

  initial begin
    int cyc;
    int ndone;
    int first_done;
    int bin_at_done;
    logic [7:0] v;

    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.bcd   = '0;

    // Reset then idle
    repeat (3) @(negedge clk);
    chk("reset_outputs", {bus.bin, bus.busy, bus.done, bus.err}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_outputs", {bus.bin, bus.busy, bus.done, bus.err}, 0);
    end

    // Sweep every valid two-digit input
    for (int t = 0; t < 100; t++) begin
      v = {4'(t / 10), 4'(t % 10)};
      conv(v, "sweep");
      @(negedge clk);
      chk("sweep_done_one_cycle", bus.done, 0);
    end

    // Invalid digits, then a valid conversion clears err
    conv(8'h3C, "invalid_3C");
    @(negedge clk);
    conv(8'hA0, "invalid_A0");
    @(negedge clk);
    conv(8'h12, "after_invalid");
    @(negedge clk);

    // Start while busy is ignored and does not queue
    bus.start = 1'b1;
    bus.bcd   = 8'h58;
    @(negedge clk);
    bus.start   = 1'b0;
    ndone       = 0;
    first_done  = 0;
    bin_at_done = 0;
    for (cyc = 1; cyc <= 22; cyc++) begin
      if (bus.done) begin
        ndone++;
        if (ndone == 1) begin
          first_done  = cyc;
          bin_at_done = int'(bus.bin);
        end
      end
      if (cyc == 4) begin
        bus.start = 1'b1;
        bus.bcd   = 8'h21;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    chk("ignored_done_count", ndone, 1);
    chk("ignored_done_cycle", first_done, 9);
    chk("ignored_bin", bin_at_done, 58);

    // Back-to-back: second start lands in the DONE cycle of the first
    conv(8'h05, "b2b_first");
    conv(8'h63, "b2b_second");
    @(negedge clk);

    // Reset in the middle of a conversion
    bus.start = 1'b1;
    bus.bcd   = 8'h77;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("midreset_busy_before", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midreset_async_outputs", {bus.bin, bus.busy, bus.done, bus.err}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("midreset_no_done", ndone, 0);
    conv(8'h77, "after_midreset");
    @(negedge clk);

    // Randomized inputs, valid and invalid, against the reference model
    for (int i = 0; i < 40; i++) begin
      v = 8'($urandom_range(0, 255));
      conv(v, "random");
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
